seq_alu: RTL
============

// Module: seq_alu
// PURPOSE
//  Parametrised, handshaked successor to the single-cycle datapath ALU.
//  Adds registered output, valid/ready flow control, and multi-cycle signed/unsigned multiply and divide producing hi/lo.
//  Sits in EX stage; stalls the pipeline via in_ready while a long op is in flight.
// PARAMETERS
//  WIDTH    32  operand/result width (>=8, power of 2); SW = $clog2(WIDTH)
//  MUL_LAT  5   cycles from accept to out_valid for MUL/MULU (>=2)
//  DIV_LAT  10  cycles from accept to out_valid for DIV/DIVU (>=2)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      operation request
//  in_ready   out  1      block can accept request this cycle
//  op         in   5      operation code (see BEHAVIOUR)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  s          in   SW     immediate shift amount
//  out_valid  out  1      result/result_hi valid
//  out_ready  in   1      consumer takes result this cycle
//  result     out  WIDTH  primary result (LO for mul/div)
//  result_hi  out  WIDTH  HI for mul/div; 0 for all other ops
//  busy       out  1      long op in progress (state BUSY)
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, result_hi=0.
//  Ops: 0 ADD a+b; 1 SUB a-b; 2 SLL b<<s; 3 SRL b>>s; 4 SRA b>>>s (signed);
//   5 SLLV b<<a[SW-1:0]; 6 SRLV; 7 SRAV; 8 AND; 9 OR; 10 XOR; 11 NOR;
//   12 SLT signed a<b ->1/0; 13 SLTU; 14 MUL signed; 15 MULU;
//   16 DIV signed; 17 DIVU; 18-31 undefined -> result=0, result_hi=0, 1-cycle.
//  Add/sub wrap modulo 2^WIDTH, no overflow flag.
//  MUL*: {result_hi,result} = full 2*WIDTH product.
//  DIV*: result=quotient (trunc toward zero), result_hi=remainder (sign of a).
//  Divide by zero: result=all ones, result_hi=a. Signed MIN/-1: result=MIN, result_hi=0.
//  FSM: IDLE -> accept when in_valid&in_ready (in_ready = state==IDLE).
//   short op (0-13, 18-31): IDLE -> HOLD; out_valid next cycle (latency 1).
//   MUL*/DIV*: IDLE -> BUSY, counter loaded LAT-1, decrements each cycle;
//    BUSY -> HOLD when counter==1; out_valid exactly LAT cycles after accept.
//   HOLD: out_valid=1, result stable; HOLD -> IDLE when out_ready.
//  Operands latched at accept; input changes during BUSY/HOLD ignored.
//  in_valid while not in_ready: ignored (no queuing); requester must hold.
//  out_ready in IDLE/BUSY: ignored. No back-to-back accept in HOLD cycle
//   (throughput 1 op / 2 cycles for short ops).
//  reset mid-BUSY or mid-HOLD: op discarded, outputs to reset values next edge.
//  Implementation free to compute mul/div iteratively or combinationally
//   and delay; visible timing must match above exactly.
// STRUCTURE
//  alu_pkg: op code localparams (OP_ADD..OP_DIVU), state encoding
//   (ST_IDLE, ST_BUSY, ST_HOLD), function for latency by op.
//  Sub-module alu_core: combinational ops 0-13 and undefined-op zeroing,
//   WIDTH-parametrised; seq_alu owns FSM, counter, mul/div, output regs.
// TESTING (WIDTH=32, MUL_LAT=5, DIV_LAT=10)
//  ADD a=7fffffff b=1, out_ready=1 -> out_valid cycle+1, result=80000000.
//  SRAV a=24 b=80000000 -> result=f8000000; SLT a=ffffffff b=1 -> 1; SLTU -> 0.
//  MUL a=ffffffff b=2 -> busy 4 cycles, out_valid at +5, hi=ffffffff lo=fffffffe;
//   MULU same operands -> hi=1 lo=fffffffe.
//  DIV a=fffffff9(-7) b=2 -> at +10 result=fffffffd, result_hi=ffffffff;
//   DIVU a=5 b=0 -> result=ffffffff, result_hi=5.
//  Backpressure: out_ready=0 for 3 cycles after result -> result stable,
//   in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
//  reset asserted at cycle 3 of DIV -> out_valid never rises, in_ready=1 after.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and per-op latency lookup for seq_alu.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_SLL  = 5'd2;
    localparam logic [4:0] OP_SRL  = 5'd3;
    localparam logic [4:0] OP_SRA  = 5'd4;
    localparam logic [4:0] OP_SLLV = 5'd5;
    localparam logic [4:0] OP_SRLV = 5'd6;
    localparam logic [4:0] OP_SRAV = 5'd7;
    localparam logic [4:0] OP_AND  = 5'd8;
    localparam logic [4:0] OP_OR   = 5'd9;
    localparam logic [4:0] OP_XOR  = 5'd10;
    localparam logic [4:0] OP_NOR  = 5'd11;
    localparam logic [4:0] OP_SLT  = 5'd12;
    localparam logic [4:0] OP_SLTU = 5'd13;
    localparam logic [4:0] OP_MUL  = 5'd14;
    localparam logic [4:0] OP_MULU = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_DIVU = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Cycles from accept to out_valid; every op outside mul/div takes one.
    function automatic int unsigned op_latency(input logic [4:0] op,
                                               input int unsigned mul_lat,
                                               input int unsigned div_lat);
        int unsigned lat;
        lat = 32'd1;
        case (op)
            OP_MUL, OP_MULU: lat = mul_lat;
            OP_DIV, OP_DIVU: lat = div_lat;
            default:         lat = 32'd1;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ops (0-13); every other code yields zero.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SW = $clog2(WIDTH)
) (
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SW-1:0]    s,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] w_res;

    // Select the short-op result; mul/div and undefined codes read as zero here.
    always_comb begin
        w_res = {WIDTH{1'b0}};
        case (op)
            OP_ADD:  w_res = a + b;
            OP_SUB:  w_res = a - b;
            OP_SLL:  w_res = b << s;
            OP_SRL:  w_res = b >> s;
            OP_SRA:  w_res = $signed(b) >>> s;
            OP_SLLV: w_res = b << a[SW-1:0];
            OP_SRLV: w_res = b >> a[SW-1:0];
            OP_SRAV: w_res = $signed(b) >>> a[SW-1:0];
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_NOR:  w_res = ~(a | b);
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: w_res = {WIDTH{1'b0}};
        endcase
    end

    assign result = w_res;

endmodule

// File: rtl/seq_alu.sv
// Handshaked EX-stage ALU: short ops in one cycle, mul/div held back to a
// fixed latency, result registered and held until the consumer takes it.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10,
    localparam int SW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SW-1:0]    s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             busy
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW = $clog2(MAX_LAT + 1);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic [WIDTH-1:0] r_pend_lo;
    logic [WIDTH-1:0] r_pend_hi;

    logic [WIDTH-1:0]   w_core;
    int unsigned        w_lat;
    logic               w_long;
    logic               w_accept;
    logic [2*WIDTH-1:0] w_long_res;

    logic [2*WIDTH-1:0] w_mul_s;
    logic [2*WIDTH-1:0] w_mul_u;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_div_zero;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;
    logic [WIDTH-1:0]   w_quo_s;
    logic [WIDTH-1:0]   w_rem_s;
    logic [WIDTH-1:0]   w_bu;
    logic [WIDTH-1:0]   w_quo_u;
    logic [WIDTH-1:0]   w_rem_u;

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op     (op),
        .a      (a),
        .b      (b),
        .s      (s),
        .result (w_core)
    );

    assign w_lat    = op_latency(op, MUL_LAT, DIV_LAT);
    assign w_long   = (w_lat > 32'd1);
    assign w_accept = in_valid && (r_state == ST_IDLE);

    // Mul/div computed from the live operands; only sampled on the accept edge.
    // Signed divide works on magnitudes so MIN/-1 wraps back to MIN with rem 0.
    always_comb begin
        w_mul_s    = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        w_mul_u    = {ZERO, a} * {ZERO, b};
        w_a_neg    = a[WIDTH-1];
        w_b_neg    = b[WIDTH-1];
        w_div_zero = (b == ZERO);
        w_a_mag    = w_a_neg ? (ZERO - a) : a;
        w_b_mag    = w_div_zero ? ONE : (w_b_neg ? (ZERO - b) : b);
        w_q_mag    = w_a_mag / w_b_mag;
        w_r_mag    = w_a_mag % w_b_mag;
        w_quo_s    = (w_a_neg ^ w_b_neg) ? (ZERO - w_q_mag) : w_q_mag;
        w_rem_s    = w_a_neg ? (ZERO - w_r_mag) : w_r_mag;
        w_bu       = w_div_zero ? ONE : b;
        w_quo_u    = a / w_bu;
        w_rem_u    = a % w_bu;
        w_long_res = {2*WIDTH{1'b0}};
        case (op)
            OP_MUL:  w_long_res = w_mul_s;
            OP_MULU: w_long_res = w_mul_u;
            OP_DIV:  w_long_res = w_div_zero ? {a, ONES} : {w_rem_s, w_quo_s};
            OP_DIVU: w_long_res = w_div_zero ? {a, ONES} : {w_rem_u, w_quo_u};
            default: w_long_res = {2*WIDTH{1'b0}};
        endcase
    end

    // Next-state logic: IDLE accepts, BUSY counts down, HOLD waits for the consumer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_next = w_long ? ST_BUSY : ST_HOLD;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (r_cnt == CW'(1)) begin
                    w_next = ST_HOLD;
                end else begin
                    w_next = ST_BUSY;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_HOLD;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, countdown and result registers; reset discards any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= {CW{1'b0}};
            r_result    <= ZERO;
            r_result_hi <= ZERO;
            r_pend_lo   <= ZERO;
            r_pend_hi   <= ZERO;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                if (w_long) begin
                    r_cnt     <= CW'(w_lat - 32'd1);
                    r_pend_lo <= w_long_res[WIDTH-1:0];
                    r_pend_hi <= w_long_res[2*WIDTH-1:WIDTH];
                end else begin
                    r_result    <= w_core;
                    r_result_hi <= ZERO;
                end
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_result    <= r_pend_lo;
                    r_result_hi <= r_pend_hi;
                end
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_HOLD);
    assign busy      = (r_state == ST_BUSY);
    assign result    = r_result;
    assign result_hi = r_result_hi;

endmodule
